// File: rtl/ama_riscv_uart_tx.sv
// UART transmitter for the core's MMIO store path.
// Buffers bytes in a small FIFO and shifts them out as 8N1 frames.
module ama_riscv_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       store_to_uart,
  input  logic [7:0] mmio_uart_data_in,
  output logic       mmio_data_in_ready,
  output logic       serial_out,
  output logic       tx_busy,
  output logic       tx_overflow
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [BW-1:0] r_baud;
  logic [BW-1:0] w_baud_nxt;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          r_tx;
  logic          w_tx_nxt;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_ready;
  logic          r_ovf;

  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_bit_end;
  logic [7:0]    w_head;

  assign w_push    = store_to_uart && r_ready;
  assign w_empty   = (r_cnt == '0);
  assign w_bit_end = (r_baud == BAUD_MAX);
  assign w_head    = r_mem[r_rptr];
  assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);

  // FIFO storage; pointers alone define which entries are valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= mmio_uart_data_in;
    end
  end

  // FIFO pointers, occupancy, registered ready and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_cnt_nxt != CNT_FULL);
      if (store_to_uart && !r_ready) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Transmit FSM state, baud/bit counters, shifter and line register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Next-state logic; the line value is computed one edge ahead
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        w_tx_nxt   = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = DATA;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = IDLE;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_baud_nxt  = '0;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  assign serial_out         = r_tx;
  assign mmio_data_in_ready = r_ready;
  assign tx_overflow        = r_ovf;
  assign tx_busy            = (r_state != IDLE) || !w_empty;

endmodule
